req_pending_tracker: RTL and testbench
======================================

Name: req_pending_tracker

Overview:
- Upstream request stage for the two-client arbiter.
- Turns single-cycle request pulses from two clients into per-client pending counts.
- Drives level request vector r[1:0] into the arbiter and consumes the arbiter's grant vector g[1:0] to retire pending requests.
- Flags overflow, spurious or conflicting grants, and starvation.

Parameters:
- CNT_W, 3, width of each pending counter; max pending per client = 2**CNT_W-1 (7).
- AGE_LIMIT, 8, cycles a client may stay pending without a consumed grant before starve[i] asserts; counter width $clog2(AGE_LIMIT+1).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- req_pulse  input  2  bit i = one new request from client i this cycle.
- g  input  2  grant vector from arbiter; bit i = grant to client i.
- r  output  2  request vector to arbiter; r[i] = (pending[i] != 0).
- pending0  output  CNT_W  pending count, client 0.
- pending1  output  CNT_W  pending count, client 1.
- full  output  2  full[i] = pending[i] == max.
- overflow  output  2  sticky; pulse dropped at full.
- spurious  output  2  sticky; g[i]=1 while pending[i]==0.
- conflict  output  1  sticky; g == 2'b11 seen.
- starve  output  2  starve[i] = age[i] == AGE_LIMIT.

Behaviour:
- All state updates on posedge clock. reset_n=0 at an edge clears pending, age, overflow, spurious, conflict and optional stats to 0. This holds mid-operation: in-flight pulses and grants in that cycle are discarded.
- After reset: r=00, full=00, starve=00.
- r, full and starve decode combinationally from registered state. A pulse at edge t is visible on r after edge t, with zero extra latency.
- Per client i, each cycle:
  - consume = g[i] & (pending[i] != 0)
  - accept = req_pulse[i] & (!full[i] | consume)
  - pending_next = pending + accept - consume, computed in CNT_W+1 bits. The result never wraps.
- Full with a simultaneous pulse and grant: count unchanged, pulse accepted, no overflow.
- Full with a pulse and no grant: pulse dropped, count unchanged, overflow[i] set.
- Grant at pending 0: no change to count, spurious[i] set. A simultaneous pulse is still accepted (count becomes 1).
- g == 11: conflict set. Each bit is still processed independently per the rules above; no arbitration is done here.
- Age counter per client:
  - Cleared when pending==0 or consume=1.
  - Otherwise increments each cycle, saturating at AGE_LIMIT.
  - starve[i] stays high until a consume or until the count drains.
- Sticky flags clear only on reset.
- No internal state machine beyond the counters. The two clients are fully independent except for conflict detection.

Optional Feature:
- Macro: GRANT_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (16 bits each). Each counts consumed grants for its client, wraps 0xFFFF->0, and resets to 0.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: hold reset_n=0 for 2 edges, then g=00 and req_pulse=00 for 5 cycles. Required: r=00, pending0=pending1=0, all flags 0.
- Fill and overflow: 8 consecutive req_pulse=01 pulses with g=00. Required:
  - pending0 reaches 7 after pulse 7; full=01.
  - Pulse 8 is dropped: pending0 stays 7, overflow=01.
  - Then g=01 for 7 cycles drains to 0 and r[0] falls.
- Simultaneous at full: pending1=7, then req_pulse=10 and g=10 in the same cycle. Required: pending1 stays 7, overflow[1]=0.
- Spurious/conflict: pending0=0, pending1=2, then g=11 for 1 cycle. Required: spurious=01, conflict=1, pending1=1, pending0=0.
- Starvation: one pulse on client 1, then g=00 for 10 cycles. Required:
  - starve[1] rises exactly 8 cycles after pending1 became 1.
  - A single g=10 clears starve[1] and pending1 on the next edge.
- Reset mid-operation: pending0=5 with overflow set; assert reset_n=0 with req_pulse=01 in the same cycle. Required after the edge: pending0=0, overflow=00, r=00.

Source files
------------

// File: rtl/req_pending_tracker.sv
// req_pending_tracker
// Upstream request stage for the two-client arbiter.
//
// - Turns single-cycle request pulses into per-client pending counts.
// - Presents a level request vector r to the arbiter.
// - Retires pending requests as the arbiter's grants are consumed.
// - Flags overflow, spurious grants, conflicting grants and starvation.
//
// Optional feature: define GRANT_STATS_EN to add the 16-bit consumed-grant
// counters grant_cnt0 and grant_cnt1.
module req_pending_tracker #(
    parameter int CNT_W     = 3,
    parameter int AGE_LIMIT = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       req_pulse,
    input  logic [1:0]       g,
    output logic [1:0]       r,
    output logic [CNT_W-1:0] pending0,
    output logic [CNT_W-1:0] pending1,
    output logic [1:0]       full,
    output logic [1:0]       overflow,
    output logic [1:0]       spurious,
    output logic             conflict,
    output logic [1:0]       starve
`ifdef GRANT_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    localparam int              AGE_W   = $clog2(AGE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    logic [CNT_W-1:0] pend     [2];
    logic [CNT_W-1:0] pend_nxt [2];
    logic [AGE_W-1:0] age      [2];
    logic [1:0]       consume;
    logic [1:0]       accept;

    assign pending0 = pend[0];
    assign pending1 = pend[1];

    // Request, full and starve levels decode straight from registered state.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            r[i]      = (pend[i] != '0);
            full[i]   = (pend[i] == CNT_MAX);
            starve[i] = (age[i] == AGE_MAX);
        end
    end

    // Next pending count: a pulse is accepted at full only when a grant frees a slot.
    // The extra width is headroom; accept/consume gating keeps the result in range.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            consume[i]  = g[i] & (pend[i] != '0);
            accept[i]   = req_pulse[i] & (~full[i] | consume[i]);
            pend_nxt[i] = CNT_W'({1'b0, pend[i]}
                                 + {{CNT_W{1'b0}}, accept[i]}
                                 - {{CNT_W{1'b0}}, consume[i]});
        end
    end

    // Counters, ages and sticky error flags; reset discards in-flight pulses and grants.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                pend[i] <= '0;
                age[i]  <= '0;
            end
            overflow <= 2'b00;
            spurious <= 2'b00;
            conflict <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                pend[i] <= pend_nxt[i];
                if ((pend[i] == '0) || consume[i])
                    age[i] <= '0;
                else if (age[i] != AGE_MAX)
                    age[i] <= age[i] + AGE_W'(1);
                if (req_pulse[i] && full[i] && !consume[i])
                    overflow[i] <= 1'b1;
                if (g[i] && (pend[i] == '0))
                    spurious[i] <= 1'b1;
            end
            if (g == 2'b11)
                conflict <= 1'b1;
        end
    end

`ifdef GRANT_STATS_EN
    // Consumed-grant statistics; wrap naturally at 16 bits.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else begin
            if (consume[0])
                grant_cnt0 <= grant_cnt0 + 16'd1;
            if (consume[1])
                grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_req_pending_tracker.sv
// Testbench for req_pending_tracker: directed vectors with hand-computed
// expectations queued by the stimulus and checked by a separate monitor.
module tb_req_pending_tracker;

    logic       clock;
    logic       reset_n;
    logic [1:0] req_pulse;
    logic [1:0] g;
    logic [1:0] r;
    logic [2:0] pending0;
    logic [2:0] pending1;
    logic [1:0] full;
    logic [1:0] overflow;
    logic [1:0] spurious;
    logic       conflict;
    logic [1:0] starve;
`ifdef GRANT_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    req_pending_tracker #(.CNT_W(3), .AGE_LIMIT(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_pulse (req_pulse),
        .g         (g),
        .r         (r),
        .pending0  (pending0),
        .pending1  (pending1),
        .full      (full),
        .overflow  (overflow),
        .spurious  (spurious),
        .conflict  (conflict),
        .starve    (starve)
`ifdef GRANT_STATS_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
`endif
    );

    typedef struct {
        string      name;
        logic [1:0] r;
        logic [2:0] p0;
        logic [2:0] p1;
        logic [1:0] full;
        logic [1:0] ovf;
        logic [1:0] spur;
        logic       conf;
        logic [1:0] starve;
    } exp_t;

    exp_t q[$];
    int   applied    = 0;
    int   miscompares = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Drive one vector before the next rising edge and queue the state expected after it.
    task automatic vec(input string nm, input logic rn, input logic [1:0] pu,
                       input logic [1:0] gr, input logic [2:0] p0, input logic [2:0] p1,
                       input logic [1:0] ov, input logic [1:0] sp, input logic cf,
                       input logic [1:0] st);
        exp_t e;
        @(negedge clock);
        reset_n   = rn;
        req_pulse = pu;
        g         = gr;
        e.name    = nm;
        e.p0      = p0;
        e.p1      = p1;
        e.r       = {p1 != 3'd0, p0 != 3'd0};
        e.full    = {p1 == 3'd7, p0 == 3'd7};
        e.ovf     = ov;
        e.spur    = sp;
        e.conf    = cf;
        e.starve  = st;
        q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare the DUT against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                applied++;
                if ({r, pending0, pending1, full, overflow, spurious, conflict, starve} !==
                    {e.r, e.p0, e.p1, e.full, e.ovf, e.spur, e.conf, e.starve}) begin
                    miscompares++;
                    $display("FAIL %s: got r=%b p0=%0d p1=%0d full=%b ovf=%b spur=%b conf=%b starve=%b, required r=%b p0=%0d p1=%0d full=%b ovf=%b spur=%b conf=%b starve=%b",
                             e.name, r, pending0, pending1, full, overflow, spurious, conflict, starve,
                             e.r, e.p0, e.p1, e.full, e.ovf, e.spur, e.conf, e.starve);
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        req_pulse = 2'b00;
        g         = 2'b00;

        // Reset then idle
        vec("reset", 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00);
        vec("reset", 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00);
        for (int k = 0; k < 5; k++)
            vec("idle", 1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00);

        // Fill client 0, then overflow on the eighth pulse
        for (int k = 1; k <= 7; k++)
            vec("fill0", 1, 2'b01, 2'b00, 3'(k), 0, 2'b00, 2'b00, 0, 2'b00);
        vec("overflow0", 1, 2'b01, 2'b00, 7, 0, 2'b01, 2'b00, 0, 2'b00);
        for (int k = 6; k >= 0; k--)
            vec("drain0", 1, 2'b00, 2'b01, 3'(k), 0, 2'b01, 2'b00, 0, 2'b00);

        // Client 1 simultaneous pulse and grant at full
        for (int k = 1; k <= 7; k++)
            vec("fill1", 1, 2'b10, 2'b00, 0, 3'(k), 2'b01, 2'b00, 0, 2'b00);
        vec("simul_full1", 1, 2'b10, 2'b10, 0, 7, 2'b01, 2'b00, 0, 2'b00);
        for (int k = 6; k >= 2; k--)
            vec("drain1", 1, 2'b00, 2'b10, 0, 3'(k), 2'b01, 2'b00, 0, 2'b00);

        // Conflicting grant with client 0 empty
        vec("conflict", 1, 2'b00, 2'b11, 0, 1, 2'b01, 2'b01, 1, 2'b00);
        vec("drain1_last", 1, 2'b00, 2'b10, 0, 0, 2'b01, 2'b01, 1, 2'b00);

        // Starvation on client 1
        vec("pulse1", 1, 2'b10, 2'b00, 0, 1, 2'b01, 2'b01, 1, 2'b00);
        for (int k = 1; k <= 10; k++)
            vec("age1", 1, 2'b00, 2'b00, 0, 1, 2'b01, 2'b01, 1, (k >= 8) ? 2'b10 : 2'b00);
        vec("unstarve1", 1, 2'b00, 2'b10, 0, 0, 2'b01, 2'b01, 1, 2'b00);

        // Reset in the middle of operation discards the concurrent pulse
        for (int k = 1; k <= 5; k++)
            vec("fill0_5", 1, 2'b01, 2'b00, 3'(k), 0, 2'b01, 2'b01, 1, 2'b00);
        vec("reset_mid", 0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00);
        vec("post_reset", 1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00);

        @(negedge clock);
        req_pulse = 2'b00;
        g         = 2'b00;
        @(negedge clock);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_queue: %0d expectations unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
